// File: rtl/nhop_out_arbiter_pkg.sv
// Shared types and defaults for the next-hop output arbiter and its per-output
// round-robin lock arbiter.
package nhop_out_arbiter_pkg;

  localparam int unsigned NumInputs    = 4;
  localparam int unsigned NextHopWidth = 4;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Index width for a pointer over n ports; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nhop_out_arbiter_rr_lock_arbiter.sv
// One output port: round-robin pick among requesters, then wormhole lock on the
// winner from head flit to tail flit.
module rr_lock_arbiter
  import nhop_out_arbiter_pkg::*;
#(
  parameter int unsigned N_IN = NumInputs
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] valid,
  input  logic [N_IN-1:0] last,
  input  logic            ready,
  output logic            out_valid,
  output logic [N_IN-1:0] out_sel,
  output logic [N_IN-1:0] lock_vec
);

  localparam int unsigned     PtrW    = ptr_width(N_IN);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(N_IN - 1);

  arb_state_e      state_q;
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] owner_q;
  logic [PtrW-1:0] win;
  logic            found;
  logic            cur_last;
  logic            xfer;

  function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] x);
    return (x == LastIdx) ? '0 : x + PtrW'(1);
  endfunction

  // First requester at or after ptr_q, wrapping modulo N_IN.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = ptr_q;
    for (int k = 0; k < int'(N_IN); k++) begin
      idx = (int'(ptr_q) + k) % int'(N_IN);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    out_sel  = '0;
    lock_vec = '0;
    if (state_q == ArbIdle) begin
      out_valid = found;
      cur_last  = last[win];
      if (found) out_sel[win] = 1'b1;
    end else begin
      // Body flits carry no route: only the owner's valid matters.
      out_valid         = valid[owner_q];
      cur_last          = last[owner_q];
      out_sel[owner_q]  = 1'b1;
      lock_vec[owner_q] = 1'b1;
    end
    if (rst) begin
      out_valid = 1'b0;
      out_sel   = '0;
    end
    xfer = out_valid & ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ArbIdle;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (xfer) begin
            if (cur_last) begin
              ptr_q <= incr(win);
            end else begin
              state_q <= ArbLocked;
              owner_q <= win;
            end
          end
        end
        ArbLocked: begin
          if (xfer && cur_last) begin
            state_q <= ArbIdle;
            ptr_q   <= incr(owner_q);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/nhop_out_arbiter.sv
// Router output-port scheduler: selects each input's effective next hop, masks
// inputs locked elsewhere, and runs one lock arbiter per output port.
module nhop_out_arbiter
  import nhop_out_arbiter_pkg::*;
#(
  parameter int unsigned N_IN  = NumInputs,
  parameter int unsigned N_OUT = NextHopWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       req_valid,
  input  logic [N_IN-1:0]       req_last,
  input  logic [N_IN-1:0]       req_mem,
  input  logic [N_IN*N_OUT-1:0] nhops,
  input  logic [N_IN*N_OUT-1:0] mem_nhops,
  input  logic [N_OUT-1:0]      out_ready,
  output logic [N_OUT-1:0]      out_valid,
  output logic [N_OUT*N_IN-1:0] out_sel,
  output logic [N_IN-1:0]       grant,
  output logic [N_IN-1:0]       err_nohop
);

  logic [N_IN-1:0][N_OUT-1:0] eh;
  logic [N_IN-1:0]            no_hop;
  logic [N_IN-1:0]            locked_any;
  logic [N_OUT-1:0][N_IN-1:0] req_o;
  logic [N_OUT-1:0][N_IN-1:0] sel_o;
  logic [N_OUT-1:0][N_IN-1:0] lock_o;
  logic [N_IN-1:0]            err_q;

  // Effective hop, reduced to its lowest set bit so each input targets one output.
  always_comb begin
    logic [N_OUT-1:0] raw;
    raw    = '0;
    eh     = '0;
    no_hop = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      raw       = req_mem[i] ? mem_nhops[i*N_OUT +: N_OUT] : nhops[i*N_OUT +: N_OUT];
      eh[i]     = raw & (~raw + N_OUT'(1));
      no_hop[i] = (raw == '0);
    end
  end

  always_comb begin
    locked_any = '0;
    for (int o = 0; o < int'(N_OUT); o++) begin
      locked_any = locked_any | lock_o[o];
    end
  end

  always_comb begin
    req_o = '0;
    for (int o = 0; o < int'(N_OUT); o++) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        req_o[o][i] = req_valid[i] & eh[i][o] & ~locked_any[i];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < int'(N_OUT); o++) begin
      grant = grant | (sel_o[o] & {N_IN{out_valid[o] & out_ready[o]}});
    end
  end

  assign out_sel   = sel_o;
  assign err_nohop = err_q;

  // A locked owner's body flits legitimately carry no route, so they never flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | (req_valid & ~locked_any & no_hop);
    end
  end

  for (genvar o = 0; o < int'(N_OUT); o++) begin : g_out
    rr_lock_arbiter #(
      .N_IN(N_IN)
    ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req_o[o]),
      .valid    (req_valid),
      .last     (req_last),
      .ready    (out_ready[o]),
      .out_valid(out_valid[o]),
      .out_sel  (sel_o[o]),
      .lock_vec (lock_o[o])
    );
  end

endmodule
